sme_aes_seq: RTL

Masked AES column sequencer. It accepts one 32-bit share-split word request and issues the four byte-select AES operations (bs = 0..3) to the `sme_crypto` unit. Each step's `rd` shares are chained back in as the next step's `rs1`, so the block returns a complete share-split SubBytes (or SubBytes+MixColumns) column result. It sits between the SME issue logic (upstream request/response handshake) and `sme_crypto` (downstream valid/ready initiator side).

---
 rtl/sme_pkg.sv | 35 +++
 rtl/sme_share_refresh.sv | 34 +++
 rtl/sme_aes_seq.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sme_pkg.sv
// sme_pkg: shared constants and types for the SME AES column sequencer.
// Build option SME_AES_SEQ_REMASK_EN (see sme_aes_seq) does not affect this file.
package sme_pkg;

  localparam int XL   = 32;                     // datapath width
  localparam int SM   = 3;                      // maximum hardware shares
  localparam int RMAX = SM + SM * (SM - 1) / 2; // guard words available on rng
  localparam int RM   = RMAX * XL;              // total rng bits

  // Sequencer state, also exported on the debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sme_state_e;

  // Byte select presented to sme_crypto.
  typedef logic [1:0] sme_bs_t;

  localparam sme_bs_t BS_LAST = 2'd3;

  // One-hot op code, bit order {aesdsm, aesds, aesesm, aeses}.
  function automatic logic [3:0] op_onehot(input logic dec, input logic mix);
    logic [3:0] v_op;
    v_op = 4'b0000;
    case ({dec, mix})
      2'b00:   v_op = 4'b0001;
      2'b01:   v_op = 4'b0010;
      2'b10:   v_op = 4'b0100;
      default: v_op = 4'b1000;
    endcase
    return v_op;
  endfunction

endpackage

// File: rtl/sme_share_refresh.sv
// sme_share_refresh: combinational share refresh. Every share except the
// last is XORed with its own rng word; the last share absorbs the XOR of
// those same words, so the unmasked value (XOR of all shares) is preserved.
// Only instantiated by sme_aes_seq when SME_AES_SEQ_REMASK_EN is defined.
module sme_share_refresh
  import sme_pkg::*;
#(
  parameter int XLEN = XL,
  parameter int SMAX = SM,
  parameter int RNUM = SMAX + SMAX * (SMAX - 1) / 2
) (
  input  logic [SMAX-1:0][XLEN-1:0] i_shares,
  input  logic [RNUM-1:0][XLEN-1:0] i_rng,
  output logic [SMAX-1:0][XLEN-1:0] o_shares
);

  logic [XLEN-1:0] w_mask_sum;
  logic            w_rng_unused;

  // Guard words beyond the first SMAX-1 are reserved for other refresh schemes.
  assign w_rng_unused = ^i_rng[RNUM-1:SMAX-1];

  // Mask the leading shares and fold the same masks into the last share.
  always_comb begin
    o_shares   = i_shares;
    w_mask_sum = '0;
    for (int i = 0; i < SMAX - 1; i++) begin
      o_shares[i] = i_shares[i] ^ i_rng[i];
      w_mask_sum  = w_mask_sum ^ i_rng[i];
    end
    o_shares[SMAX-1] = i_shares[SMAX-1] ^ w_mask_sum;
  end

endmodule

// File: rtl/sme_aes_seq.sv
// sme_aes_seq: masked AES column sequencer. One accepted request drives four
// byte-select steps (bs = 0..3) through sme_crypto, feeding each step's rd
// shares back in as the next step's rs1, and returns the whole column result.
// Build option: define SME_AES_SEQ_REMASK_EN to refresh the captured shares
// from rng on every step; otherwise rng is ignored. Timing is identical.
//
// Handshakes (all strict valid/ready): a transfer happens on a rising edge
// where valid && ready. req_ready is high only in IDLE (and not during flush);
// rsp_valid is high only in DONE and holds rsp_rd stable until rsp_ready;
// cu_valid is high throughout RUN and only drops after the last cu_ready,
// on flush or on reset.
module sme_aes_seq
  import sme_pkg::*;
#(
  parameter  int XLEN = XL,
  parameter  int SMAX = SM,
  localparam int RNUM = SMAX + SMAX * (SMAX - 1) / 2
) (
  input  logic                      g_clk,
  input  logic                      g_resetn,
  output logic                      g_clk_req,
  input  logic                      flush,
  input  logic [RNUM-1:0][XLEN-1:0] rng,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_dec,
  input  logic                      req_mix,
  input  logic [SMAX-1:0][XLEN-1:0] req_rs1,
  input  logic [SMAX-1:0][XLEN-1:0] req_rs2,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [SMAX-1:0][XLEN-1:0] rsp_rd,
  output logic                      cu_valid,
  input  logic                      cu_ready,
  output logic                      cu_op_aeses,
  output logic                      cu_op_aesesm,
  output logic                      cu_op_aesds,
  output logic                      cu_op_aesdsm,
  output sme_bs_t                   cu_bs,
  output logic [SMAX-1:0][XLEN-1:0] cu_rs1,
  output logic [SMAX-1:0][XLEN-1:0] cu_rs2,
  input  logic [SMAX-1:0][XLEN-1:0] cu_rd,
  output logic                      cu_flush,
  output logic [1:0]                dbg_state
);

  sme_state_e                r_state;
  sme_state_e                w_state_nxt;
  sme_bs_t                   r_bs_ctr;
  logic [SMAX-1:0][XLEN-1:0] r_acc;
  logic [SMAX-1:0][XLEN-1:0] r_rs2;
  logic                      r_dec;
  logic                      r_mix;
  logic [SMAX-1:0][XLEN-1:0] w_cap;
  logic [3:0]                w_op;
  logic                      w_accept;
  logic                      w_step;
  logic                      w_last;
  logic                      w_rsp_done;

  // Handshake events, derived from state directly so they never loop
  // through the combinational output block.
  assign w_accept   = (r_state == IDLE) && req_valid && !flush;
  assign w_step     = (r_state == RUN) && cu_ready;
  assign w_last     = (r_bs_ctr == BS_LAST);
  assign w_rsp_done = (r_state == DONE) && rsp_ready;

`ifdef SME_AES_SEQ_REMASK_EN
  sme_share_refresh #(
    .XLEN (XLEN),
    .SMAX (SMAX),
    .RNUM (RNUM)
  ) u_share_refresh (
    .i_shares (cu_rd),
    .i_rng    (rng),
    .o_shares (w_cap)
  );
`else
  logic w_rng_unused;

  assign w_cap        = cu_rd;
  assign w_rng_unused = ^rng;
`endif

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake outputs; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    cu_valid    = 1'b0;
    rsp_rd      = '0;
    w_op        = 4'b0000;
    case (r_state)
      IDLE: begin
        req_ready = !flush;
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        cu_valid = 1'b1;
        w_op     = op_onehot(r_dec, r_mix);
        if (cu_ready && w_last) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        rsp_valid = 1'b1;
        rsp_rd    = r_acc;
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
    end
  end

  // Request latch, accumulator chaining and byte-select counter. The counter
  // naturally wraps 3 -> 0 on the last step, which leaves it ready for the
  // next request; the accumulator is cleared once the result is consumed so
  // nothing stale lingers between operations.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_acc    <= '0;
      r_rs2    <= '0;
      r_dec    <= 1'b0;
      r_mix    <= 1'b0;
      r_bs_ctr <= '0;
    end else if (flush) begin
      r_acc    <= '0;
      r_rs2    <= '0;
      r_dec    <= 1'b0;
      r_mix    <= 1'b0;
      r_bs_ctr <= '0;
    end else if (w_accept) begin
      r_acc    <= req_rs1;
      r_rs2    <= req_rs2;
      r_dec    <= req_dec;
      r_mix    <= req_mix;
      r_bs_ctr <= '0;
    end else if (w_step) begin
      r_acc    <= w_cap;
      r_bs_ctr <= r_bs_ctr + 2'd1;
    end else if (w_rsp_done) begin
      r_acc    <= '0;
    end
  end

  assign g_clk_req    = (r_state != IDLE);
  assign cu_flush     = flush;
  assign cu_bs        = r_bs_ctr;
  assign cu_rs1       = r_acc;
  assign cu_rs2       = r_rs2;
  assign cu_op_aeses  = w_op[0];
  assign cu_op_aesesm = w_op[1];
  assign cu_op_aesds  = w_op[2];
  assign cu_op_aesdsm = w_op[3];
  assign dbg_state    = r_state;

endmodule
